// File: rtl/mem_arbiter.sv
// Byte-serial sequencer that shares a single-port 8-bit RAM between the
// instruction fetcher (pipelined bursts) and the load/store unit.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 16,
  localparam int unsigned IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  output logic                  ram_wr_out,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [7:0]            ram_dout_out,
  input  logic [7:0]            ram_din_in,
  input  logic                  io_buffer_full_in,
  input  logic                  flush_in,
  input  logic                  ifetch_req_in,
  input  logic [ADDR_WIDTH-1:0] ifetch_addr_in,
  output logic                  ifetch_word_valid_out,
  output logic [31:0]           ifetch_word_out,
  output logic [IDX_W-1:0]      ifetch_word_idx_out,
  output logic                  ifetch_done_out,
  input  logic                  lsu_req_in,
  input  logic                  lsu_we_in,
  input  logic [1:0]            lsu_size_in,
  input  logic                  lsu_signed_in,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_in,
  input  logic [31:0]           lsu_wdata_in,
  output logic [31:0]           lsu_rdata_out,
  output logic                  lsu_done_out
);

  localparam int unsigned CNT_W = $clog2(4 * LINE_WORDS) + 2;
  localparam logic [CNT_W-1:0] FETCH_BYTES = CNT_W'(4 * LINE_WORDS);

  typedef enum logic [2:0] {IDLE, LSU_RD, LSU_WR, FETCH, DONE} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx, cnt_inc, cnt_m1;
  logic [CNT_W-1:0]      len, len_nx, lsu_len;
  logic [ADDR_WIDTH-1:0] base, base_nx;
  logic [31:0]           wdata, wdata_nx;
  logic                  sgn, sgn_nx;
  logic [31:0]           acc, acc_nx;

  logic                  wr_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [7:0]            dout_nx;
  logic                  fv_nx, fdone_nx, ldone_nx;
  logic [31:0]           fword_nx, rdata_nx;
  logic [IDX_W-1:0]      fidx_nx;

  logic io_blocked, lsu_go, fetch_go;

  // A store into the IO region is held off while the IO buffer is full.
  assign io_blocked = lsu_we_in && (lsu_addr_in[17:16] == 2'b11) && io_buffer_full_in;
  assign lsu_go     = lsu_req_in && !io_blocked;
  assign fetch_go   = ifetch_req_in && !flush_in;
  assign cnt_inc    = cnt + CNT_W'(1);
  assign cnt_m1     = cnt - CNT_W'(1);

  always_comb begin
    case (lsu_size_in)
      2'd0:    lsu_len = CNT_W'(1);
      2'd1:    lsu_len = CNT_W'(2);
      default: lsu_len = CNT_W'(4);
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   state <= IDLE;
    else if (rdy_in) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (lsu_go)        state_nx = lsu_we_in ? LSU_WR : LSU_RD;
        else if (fetch_go) state_nx = FETCH;
      end
      LSU_WR: if (cnt_inc == len) state_nx = DONE;
      LSU_RD: if (cnt == len) state_nx = DONE;
      FETCH: begin
        if (flush_in)        state_nx = IDLE;
        else if (cnt == len) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt counts cycles since grant; a read byte lands one cycle after its address.
  always_comb begin
    cnt_nx   = cnt_inc;
    len_nx   = len;
    base_nx  = base;
    wdata_nx = wdata;
    sgn_nx   = sgn;
    acc_nx   = acc;
    wr_nx    = 1'b0;
    addr_nx  = '0;
    dout_nx  = '0;
    fv_nx    = 1'b0;
    fword_nx = '0;
    fidx_nx  = '0;
    fdone_nx = 1'b0;
    ldone_nx = 1'b0;
    rdata_nx = '0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        acc_nx = '0;
        if (lsu_go) begin
          len_nx   = lsu_len;
          base_nx  = lsu_addr_in;
          wdata_nx = lsu_wdata_in;
          sgn_nx   = lsu_signed_in;
          addr_nx  = lsu_addr_in;
          wr_nx    = lsu_we_in;
          dout_nx  = lsu_we_in ? lsu_wdata_in[7:0] : '0;
        end else if (fetch_go) begin
          len_nx  = FETCH_BYTES;
          base_nx = ifetch_addr_in;
          addr_nx = ifetch_addr_in;
        end
      end
      LSU_WR: begin
        if (cnt_inc != len) begin
          wr_nx   = 1'b1;
          addr_nx = base + ADDR_WIDTH'(cnt_inc);
          dout_nx = wdata[{cnt_inc[1:0], 3'b000} +: 8];
        end else begin
          ldone_nx = 1'b1;
        end
      end
      LSU_RD: begin
        if (cnt_inc < len) addr_nx = base + ADDR_WIDTH'(cnt_inc);
        if (cnt != '0) acc_nx[{cnt_m1[1:0], 3'b000} +: 8] = ram_din_in;
        if (cnt == len) begin
          ldone_nx = 1'b1;
          if (len == CNT_W'(1))
            rdata_nx = {{24{sgn & acc_nx[7]}}, acc_nx[7:0]};
          else if (len == CNT_W'(2))
            rdata_nx = {{16{sgn & acc_nx[15]}}, acc_nx[15:0]};
          else
            rdata_nx = acc_nx;
        end
      end
      FETCH: begin
        if (flush_in) begin
          cnt_nx = '0;
        end else begin
          if (cnt_inc < len) addr_nx = base + ADDR_WIDTH'(cnt_inc);
          if (cnt != '0) begin
            acc_nx[{cnt_m1[1:0], 3'b000} +: 8] = ram_din_in;
            if (cnt_m1[1:0] == 2'b11) begin
              fv_nx    = 1'b1;
              fword_nx = acc_nx;
              fidx_nx  = IDX_W'(cnt_m1 >> 2);
            end
            if (cnt == len) fdone_nx = 1'b1;
          end
        end
      end
      DONE:    cnt_nx = '0;
      default: cnt_nx = '0;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt                   <= '0;
      len                   <= '0;
      base                  <= '0;
      wdata                 <= '0;
      sgn                   <= 1'b0;
      acc                   <= '0;
      ram_wr_out            <= 1'b0;
      ram_addr_out          <= '0;
      ram_dout_out          <= '0;
      ifetch_word_valid_out <= 1'b0;
      ifetch_word_out       <= '0;
      ifetch_word_idx_out   <= '0;
      ifetch_done_out       <= 1'b0;
      lsu_rdata_out         <= '0;
      lsu_done_out          <= 1'b0;
    end else if (rdy_in) begin
      cnt                   <= cnt_nx;
      len                   <= len_nx;
      base                  <= base_nx;
      wdata                 <= wdata_nx;
      sgn                   <= sgn_nx;
      acc                   <= acc_nx;
      ram_wr_out            <= wr_nx;
      ram_addr_out          <= addr_nx;
      ram_dout_out          <= dout_nx;
      ifetch_word_valid_out <= fv_nx;
      ifetch_word_out       <= fword_nx;
      ifetch_word_idx_out   <= fidx_nx;
      ifetch_done_out       <= fdone_nx;
      lsu_rdata_out         <= rdata_nx;
      lsu_done_out          <= ldone_nx;
    end
  end

endmodule
